// File: rtl/lvl_states_ram_arbiter.sv
// Round-robin owner arbiter for the single-port level-states BRAM shared by NUM_REQ requesters.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN (adds timeout_o, limit MAX_HOLD).
module lvl_states_ram_arbiter #(
    parameter int unsigned WIDTH_LVL_STATES       = 30,
    parameter int unsigned ADDR_WIDTH_LVLS_STATES = 9,
    parameter int unsigned NUM_REQ                = 3,
    parameter int unsigned RD_LATENCY             = 1,
    parameter int unsigned MAX_HOLD               = 1023
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_apply_i,
    input  logic [NUM_REQ-1:0]                        req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH_LVLS_STATES-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH_LVL_STATES-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]                        grant_o,
    output logic [WIDTH_LVL_STATES-1:0]               rd_data_o,
    output logic [NUM_REQ-1:0]                        rd_valid_o,
    output logic                                      ram_we_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0]         ram_addr_o,
    output logic [WIDTH_LVL_STATES-1:0]               ram_data_o,
    input  logic [WIDTH_LVL_STATES-1:0]               ram_data_i,
    output logic                                      busy_o
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                                      timeout_o
`endif
);

    localparam int unsigned DW    = WIDTH_LVL_STATES;
    localparam int unsigned AW    = ADDR_WIDTH_LVLS_STATES;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_rd_latency
        $error("RD_LATENCY must be in 1..3");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [NUM_REQ-1:0]   rd_pipe_q [RD_LATENCY];

    logic [AW-1:0]        addr_arr [NUM_REQ];
    logic [DW-1:0]        data_arr [NUM_REQ];

    logic                 pick_vld_c;
    logic [IDX_W-1:0]     pick_idx_c;
    int unsigned          cand_c;
    logic                 owned_c;
    logic                 own_apply_c;
    logic                 own_we_c;
    logic                 hold_exp_c;
    logic                 release_c;
    logic [NUM_REQ-1:0]   rd_issue_c;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k] = req_addr_i[k*AW +: AW];
        assign data_arr[k] = req_data_i[k*DW +: DW];
    end

    // First applying requester at or above the pointer, wrapping around.
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        cand_c     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = 32'(ptr_q) + i;
            if (cand_c >= NUM_REQ) begin
                cand_c = cand_c - NUM_REQ;
            end
            if (!pick_vld_c && req_apply_i[IDX_W'(cand_c)]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = IDX_W'(cand_c);
            end
        end
    end

    // Owner's port is steered straight onto the BRAM; everything is zero without an owner.
    always_comb begin
        owned_c     = (state_q == ST_OWNED);
        own_apply_c = owned_c & req_apply_i[owner_q];
        own_we_c    = req_we_i[owner_q];
        ram_we_o    = own_apply_c & own_we_c;
        ram_addr_o  = owned_c ? addr_arr[owner_q] : '0;
        ram_data_o  = owned_c ? data_arr[owner_q] : '0;
        rd_issue_c  = (own_apply_c & ~own_we_c) ? grant_q : '0;
        release_c   = owned_c & (~req_apply_i[owner_q] | hold_exp_c);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;

    assign hold_exp_c = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign timeout_o  = timeout_q;

    // Counts cycles of the current ownership; cleared on every new grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= release_c & hold_exp_c;
            if (state_q == ST_IDLE) begin
                hold_q <= '0;
            end else if (owned_c) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
        end
    end
`else
    assign hold_exp_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            // One-hot read tags ride alongside the BRAM read latency.
            rd_pipe_q[0] <= rd_issue_c;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_c) begin
                        grant_q <= NUM_REQ'(1) << pick_idx_c;
                        owner_q <= pick_idx_c;
                        state_q <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (release_c) begin
                        grant_q <= '0;
                        ptr_q   <= (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = |grant_q;
    assign rd_valid_o = rd_pipe_q[RD_LATENCY-1];
    assign rd_data_o  = ram_data_i;

endmodule

// File: tb/tb_lvl_states_ram_arbiter.sv
// Bench for lvl_states_ram_arbiter: two instances (read latency 1 and 3) driven in lockstep,
// each with its own BRAM model; read returns are checked against a queue of expected results.
module tb_lvl_states_ram_arbiter;

    localparam int unsigned DW       = 30;
    localparam int unsigned AW       = 9;
    localparam int unsigned NR       = 3;
    localparam int unsigned MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [NR-1:0]    apply = '0;
    logic [NR-1:0]    we    = '0;
    logic [NR*AW-1:0] addr  = '0;
    logic [NR*DW-1:0] wdata = '0;

    logic [NR-1:0] grant1, rdv1, grant3, rdv3;
    logic [DW-1:0] rdd1, ramd_o1, ramd_i1, rdd3, ramd_o3, ramd_i3;
    logic [AW-1:0] rama1, rama3;
    logic          ramwe1, ramwe3, busy1, busy3;
`ifdef ARB_TIMEOUT_EN
    logic          to1, to3;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int            due;
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t q1[$];
    rd_exp_t q3[$];
    rd_exp_t e1, e3;

    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] mem1 [512];
    logic [DW-1:0] mem3 [512];
    logic          wr1  [512];
    logic          wr3  [512];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lvl_states_ram_arbiter #(
        .WIDTH_LVL_STATES(DW), .ADDR_WIDTH_LVLS_STATES(AW), .NUM_REQ(NR),
        .RD_LATENCY(1), .MAX_HOLD(MAX_HOLD)
    ) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_apply_i(apply), .req_we_i(we), .req_addr_i(addr), .req_data_i(wdata),
        .grant_o(grant1), .rd_data_o(rdd1), .rd_valid_o(rdv1),
        .ram_we_o(ramwe1), .ram_addr_o(rama1), .ram_data_o(ramd_o1), .ram_data_i(ramd_i1),
        .busy_o(busy1)
`ifdef ARB_TIMEOUT_EN
        , .timeout_o(to1)
`endif
    );

    lvl_states_ram_arbiter #(
        .WIDTH_LVL_STATES(DW), .ADDR_WIDTH_LVLS_STATES(AW), .NUM_REQ(NR),
        .RD_LATENCY(3), .MAX_HOLD(MAX_HOLD)
    ) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_apply_i(apply), .req_we_i(we), .req_addr_i(addr), .req_data_i(wdata),
        .grant_o(grant3), .rd_data_o(rdd3), .rd_valid_o(rdv3),
        .ram_we_o(ramwe3), .ram_addr_o(rama3), .ram_data_o(ramd_o3), .ram_data_i(ramd_i3),
        .busy_o(busy3)
`ifdef ARB_TIMEOUT_EN
        , .timeout_o(to3)
`endif
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            9'd5:    return 30'h15;
            9'd6:    return 30'h2A;
            default: return DW'(a) * 30'd7 + 30'd3;
        endcase
    endfunction

    // Read-first BRAM models; unwritten locations return their preload pattern.
    always @(posedge clk) begin
        if (ramwe1) begin
            mem1[rama1] <= ramd_o1;
            wr1[rama1]  <= 1'b1;
        end
        p1 <= (wr1[rama1] === 1'b1) ? mem1[rama1] : init_val(rama1);
    end
    assign ramd_i1 = p1;

    always @(posedge clk) begin
        if (ramwe3) begin
            mem3[rama3] <= ramd_o3;
            wr3[rama3]  <= 1'b1;
        end
        p3[0] <= (wr3[rama3] === 1'b1) ? mem3[rama3] : init_val(rama3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ramd_i3 = p3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int k, input logic ap, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        apply[k]         = ap;
        we[k]            = w;
        addr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    // A read issued in the current cycle returns RD_LATENCY cycles later.
    task automatic exp_rd(input int k, input logic [AW-1:0] a);
        q1.push_back('{due: cyc + 1, vld: NR'(1) << k, data: ref_mem[a]});
        q3.push_back('{due: cyc + 3, vld: NR'(1) << k, data: ref_mem[a]});
    endtask

    task automatic chk_grant(input string tag, input logic [NR-1:0] g);
        chk(tag, 64'(grant1), 64'(g));
        chk({tag, "_l3"}, 64'(grant3), 64'(g));
        chk({tag, "_busy"}, 64'(busy1), 64'(|g));
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e1 = q1.pop_front();
            chk("rd_valid_l1", 64'(rdv1), 64'(e1.vld));
            chk("rd_data_l1", 64'(rdd1), 64'(e1.data));
        end else begin
            chk("rd_valid_l1_idle", 64'(rdv1), 64'h0);
        end
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e3 = q3.pop_front();
            chk("rd_valid_l3", 64'(rdv3), 64'(e3.vld));
            chk("rd_data_l3", 64'(rdd3), 64'(e3.data));
        end else begin
            chk("rd_valid_l3_idle", 64'(rdv3), 64'h0);
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = init_val(AW'(i));
        end

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        chk_grant("rst_grant", 3'b000);
        chk("rst_we", 64'(ramwe1), 64'h0);
        chk("rst_addr", 64'(rama1), 64'h0);
        rst = 1'b1;
        tick();

        // Single requester: reads addr 5 then 6
        set_req(0, 1'b1, 1'b0, 9'd5, '0);
        settle();
        chk("idle_addr", 64'(rama1), 64'h0);
        chk_grant("t1_pre", 3'b000);
        tick(); settle();
        chk_grant("t1_grant", 3'b001);
        chk("t1_addr5", 64'(rama1), 64'd5);
        chk("t1_we", 64'(ramwe1), 64'h0);
        exp_rd(0, 9'd5);
        tick(); set_req(0, 1'b1, 1'b0, 9'd6, '0); settle();
        chk("t1_addr6", 64'(rama1), 64'd6);
        exp_rd(0, 9'd6);
        tick(); set_req(0, 1'b0, 1'b0, '0, '0); settle();
        chk_grant("t1_drop", 3'b001);
        tick(); settle();
        chk_grant("t1_release", 3'b000);
        chk("t1_rel_addr", 64'(rama1), 64'h0);
        tick();

        // Reset in the middle of a req1 burst drops the in-flight read
        set_req(1, 1'b1, 1'b0, 9'd4, '0);
        tick(); settle();
        chk_grant("rst_owned", 3'b010);
        rst = 1'b0;
        tick(); settle();
        chk_grant("rst_mid", 3'b000);
        chk("rst_mid_we", 64'(ramwe1), 64'h0);
        chk("rst_mid_rdv", 64'(rdv1), 64'h0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick(); rst = 1'b1;
        tick();

        // Simultaneous requests from pointer 0: order 0, 1, 2, then 0 again
        set_req(0, 1'b1, 1'b0, 9'd1, '0);
        set_req(1, 1'b1, 1'b0, 9'd2, '0);
        set_req(2, 1'b1, 1'b0, 9'd3, '0);
        tick(); settle();
        chk_grant("rr_g0", 3'b001);
        set_req(0, 1'b0, 1'b0, 9'd1, '0);
        tick(); settle();
        chk_grant("rr_bubble0", 3'b000);
        tick(); set_req(0, 1'b1, 1'b0, 9'd1, '0); settle();
        chk_grant("rr_idle0", 3'b000);
        tick(); settle();
        chk_grant("rr_g1", 3'b010);
        chk("rr_addr1", 64'(rama1), 64'd2);
        exp_rd(1, 9'd2);
        tick(); set_req(1, 1'b0, 1'b0, 9'd2, '0);
        tick(); settle();
        chk_grant("rr_bubble1", 3'b000);
        tick(); settle();
        chk_grant("rr_idle1", 3'b000);
        tick(); settle();
        chk_grant("rr_g2", 3'b100);
        exp_rd(2, 9'd3);
        tick(); set_req(2, 1'b0, 1'b0, 9'd3, '0);
        tick(); settle();
        chk_grant("rr_bubble2", 3'b000);
        tick();
        tick(); settle();
        chk_grant("rr_g0_again", 3'b001);
        exp_rd(0, 9'd1);
        tick(); set_req(0, 1'b0, 1'b0, '0, '0);
        tick(); tick();

        // Write isolation: req2 writes while req0 drives a conflicting write
        set_req(0, 1'b1, 1'b1, 9'd9, 30'h0);
        set_req(2, 1'b1, 1'b1, 9'd9, 30'h3FF);
        tick(); settle();
        chk_grant("wr_grant", 3'b100);
        chk("wr_we", 64'(ramwe1), 64'h1);
        chk("wr_addr", 64'(rama1), 64'd9);
        chk("wr_data", 64'(ramd_o1), 64'h3FF);
        ref_mem[9] = 30'h3FF;
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b0, 1'b0, '0, '0);
        settle();
        chk("wr_drop_we", 64'(ramwe1), 64'h0);
        tick(); settle();
        chk("wr_mem_l1", 64'(mem1[9]), 64'h3FF);
        chk("wr_mem_l3", 64'(mem3[9]), 64'h3FF);
        set_req(0, 1'b1, 1'b0, 9'd9, '0);
        tick();
        tick(); settle();
        chk_grant("wr_rd_grant", 3'b001);
        exp_rd(0, 9'd9);
        tick(); set_req(0, 1'b0, 1'b0, '0, '0);
        tick(); tick();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: req1 holds while req2 waits
        set_req(1, 1'b1, 1'b0, 9'd7, '0);
        set_req(2, 1'b1, 1'b0, 9'd8, '0);
        tick(); settle();
        chk_grant("to_grant", 3'b010);
        chk("to_idle", 64'(to1), 64'h0);
        exp_rd(1, 9'd7);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk_grant("to_hold", 3'b010);
            exp_rd(1, 9'd7);
        end
        tick(); settle();
        chk_grant("to_revoked", 3'b000);
        chk("to_pulse", 64'(to1), 64'h1);
        chk("to_pulse_l3", 64'(to3), 64'h1);
        tick(); settle();
        chk("to_pulse_end", 64'(to1), 64'h0);
        tick(); settle();
        chk_grant("to_next", 3'b100);
        exp_rd(2, 9'd8);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick(); set_req(2, 1'b0, 1'b0, '0, '0);
        tick(); tick(); tick();
`endif

        // Late read: last read completes after the grant has cleared
        set_req(1, 1'b1, 1'b0, 9'd6, '0);
        tick(); settle();
        chk_grant("late_grant", 3'b010);
        exp_rd(1, 9'd6);
        tick(); set_req(1, 1'b0, 1'b0, '0, '0); settle();
        chk_grant("late_drop", 3'b010);
        tick(); settle();
        chk_grant("late_rel", 3'b000);
        tick(); settle();
        chk("late_rdv_l3", 64'(rdv3), 64'h2);
        chk("late_rdd_l3", 64'(rdd3), 64'h2A);
        chk("late_grant_l3", 64'(grant3), 64'h0);

        repeat (5) tick();
        chk("q1_drained", 64'(q1.size()), 64'h0);
        chk("q3_drained", 64'(q3.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lvl_states_ram_arbiter.md
Name: lvl_states_ram_arbiter

Overview:
- Shares the single-port level-states BRAM (per-level {bin id, has_bkt} records) among NUM_REQ requesters: global backtrack-level finder, level-state updater, bin loader.
- Each requester holds a persistent apply signal for the whole access burst. The arbiter grants one owner at a time, round-robin.
- The owner's we/addr/data are muxed onto the BRAM. Read data is routed back with a per-requester valid.
- Sits between bin_manager sub-blocks and the lvl-states BRAM.

Parameters:
- WIDTH_LVL_STATES, 30, BRAM data width
- ADDR_WIDTH_LVLS_STATES, 9, BRAM address width
- NUM_REQ, 3, number of requesters (2..8)
- RD_LATENCY, 1, BRAM read latency in cycles (1..3)
- MAX_HOLD, 1023, grant watchdog limit in cycles; used only with ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- req_apply_i  in  NUM_REQ  per-requester persistent access request
- req_we_i  in  NUM_REQ  per-requester write enable
- req_addr_i  in  NUM_REQ*ADDR_WIDTH_LVLS_STATES  packed addresses; requester k at slice k
- req_data_i  in  NUM_REQ*WIDTH_LVL_STATES  packed write data
- grant_o  out  NUM_REQ  one-hot grant, registered
- rd_data_o  out  WIDTH_LVL_STATES  BRAM read data, broadcast to all requesters
- rd_valid_o  out  NUM_REQ  one-hot; rd_data_o is valid for requester k
- ram_we_o  out  1  BRAM write enable
- ram_addr_o  out  ADDR_WIDTH_LVLS_STATES  BRAM address
- ram_data_o  out  WIDTH_LVL_STATES  BRAM write data
- ram_data_i  in  WIDTH_LVL_STATES  BRAM read data
- busy_o  out  1  high whenever grant_o != 0
- timeout_o  out  1  watchdog pulse; present only with ARB_TIMEOUT_EN

Behaviour:
- Reset (rst==0 at posedge): all outputs 0, state IDLE, round-robin pointer 0, read-tag pipeline cleared. Applies mid-burst too; any in-flight read valid is dropped.
- States: IDLE, OWNED, RELEASE.
- IDLE:
  - If any req_apply_i is set, pick the first set bit searching from pointer upward with wrap.
  - Register grant_o one-hot for that requester; next state OWNED.
  - Latency: apply rises at edge t, grant_o is high after edge t+1.
- OWNED:
  - ram_we_o = req_we_i[owner] & req_apply_i[owner].
  - ram_addr_o / ram_data_o = owner's slices. Combinational mux, so no added latency.
  - Non-owner inputs are ignored entirely.
  - When req_apply_i[owner] goes low: grant_o cleared at the next edge, state RELEASE, pointer = owner+1 mod NUM_REQ.
- RELEASE:
  - One bubble cycle with ram_we_o=0, then IDLE. Guarantees a one-cycle gap between owners.
- ram_we_o, ram_addr_o and ram_data_o are 0 whenever there is no owner.
- Read return:
  - Every OWNED cycle with apply high and we low issues a read tagged with the owner index.
  - The tag goes through a RD_LATENCY-deep valid/tag shift register.
  - rd_valid_o[tag] is asserted exactly RD_LATENCY cycles after the address cycle.
  - This still holds after grant is released: reads issued in the last owned cycle still complete.
  - Write cycles produce no rd_valid.
- Simultaneous requests: strict round-robin from pointer. Requester k cannot win twice in a row while another requester is waiting.
- An owner that raises and drops apply in the same cycle as its grant still gets one OWNED cycle.
- An apply pulse that drops before grant is simply lost. Requesters must hold apply until grant_o.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A hold counter counts OWNED cycles.
  - Reaching MAX_HOLD forces grant_o=0, RELEASE, and a one-cycle timeout_o=1; the pointer advances past the offender.
- When undefined: no counter, no timeout_o port, and a grant is held indefinitely.

Test Plan:
- Reset: assert rst=0 during an OWNED burst on req1 -> next cycle grant_o=0, ram_we_o=0, rd_valid_o=0, pointer 0.
- Single requester: req0 apply at t, reads addr 5 then 6 (RAM holds 0x15, 0x2A), RD_LATENCY=1 -> grant_o=001 at t+1; rd_valid_o[0] with rd_data_o=0x15 then 0x2A, one cycle after each address.
- Simultaneous requests, pointer 0: req0, req1 and req2 all apply -> grant order 0, 1, 2, each separated by one RELEASE bubble; req0 re-applies after release and is granted only after req2.
- Write isolation: req2 owns and writes 0x3FF to addr 9 while req0 drives we=1, addr 9, data 0 -> RAM addr 9 = 0x3FF; req0 write is ignored.
- Late read: owner drops apply the cycle after its last read, RD_LATENCY=3 -> rd_valid_o for that owner arrives 3 cycles after the address cycle, after grant_o has cleared.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: req1 holds apply 10 cycles while req2 waits -> grant revoked after 4 OWNED cycles, timeout_o pulse, req2 granted next.
